// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV32I pipeline: ALU op encodings, register-index width
// and the decoded control bundle carried from ID to EX.
package rv_pipe_pkg;

    localparam int ALU_W = 4;
    localparam int REG_W = 5;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic alu_src;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
        logic branch;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection for the ID/EX boundary. A taken branch in EX
// squashes the ID instruction, so it overrides the stall.
module hazard_detect
    import rv_pipe_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_flush,
    output logic             load_use,
    output logic             stall_if_id,
    output logic             flush_if_id
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit     = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit     = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use    = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
    assign stall_if_id = load_use && !ex_flush;
    assign flush_if_id = ex_flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion on load-use or flush, plus
// saturating stall/flush event counters for performance debug.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int ALU_W = rv_pipe_pkg::ALU_W,
    parameter int CNT_W = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [XLEN-1:0]             id_pc,
    input  logic [rv_pipe_pkg::REG_W-1:0] id_rs1,
    input  logic [rv_pipe_pkg::REG_W-1:0] id_rs2,
    input  logic                        id_uses_rs1,
    input  logic                        id_uses_rs2,
    input  logic [rv_pipe_pkg::REG_W-1:0] id_rd,
    input  logic [XLEN-1:0]             id_rs1_data,
    input  logic [XLEN-1:0]             id_rs2_data,
    input  logic [XLEN-1:0]             id_imm,
    input  logic [ALU_W-1:0]            id_alu_ctrl,
    input  logic                        id_alu_src,
    input  logic                        id_mem_read,
    input  logic                        id_mem_write,
    input  logic                        id_mem_to_reg,
    input  logic                        id_reg_write,
    input  logic                        id_branch,
    input  logic                        ex_flush,
    output logic                        stall_if_id,
    output logic                        flush_if_id,
    output logic                        ex_valid,
    output logic [XLEN-1:0]             ex_pc,
    output logic [XLEN-1:0]             ex_rs1_data,
    output logic [XLEN-1:0]             ex_rs2_data,
    output logic [XLEN-1:0]             ex_imm,
    output logic [rv_pipe_pkg::REG_W-1:0] ex_rs1,
    output logic [rv_pipe_pkg::REG_W-1:0] ex_rs2,
    output logic [rv_pipe_pkg::REG_W-1:0] ex_rd,
    output logic [ALU_W-1:0]            ex_alu_ctrl,
    output logic                        ex_alu_src,
    output logic                        ex_mem_read,
    output logic                        ex_mem_write,
    output logic                        ex_mem_to_reg,
    output logic                        ex_reg_write,
    output logic                        ex_branch,
    output logic [CNT_W-1:0]            stall_count,
    output logic [CNT_W-1:0]            flush_count
);

    import rv_pipe_pkg::*;

    logic             load_use;
    ctrl_t            id_ctrl;
    ctrl_t            ctrl_d,    ctrl_q;
    logic             valid_d,   valid_q;
    logic [XLEN-1:0]  pc_d,      pc_q;
    logic [XLEN-1:0]  rs1_dat_d, rs1_dat_q;
    logic [XLEN-1:0]  rs2_dat_d, rs2_dat_q;
    logic [XLEN-1:0]  imm_d,     imm_q;
    logic [REG_W-1:0] rs1_d,     rs1_q;
    logic [REG_W-1:0] rs2_d,     rs2_q;
    logic [REG_W-1:0] rd_d,      rd_q;
    logic [ALU_W-1:0] alu_d,     alu_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    hazard_detect u_hazard (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .ex_flush    (ex_flush),
        .load_use    (load_use),
        .stall_if_id (stall_if_id),
        .flush_if_id (flush_if_id)
    );

    assign id_ctrl = '{alu_src:    id_alu_src,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       mem_to_reg: id_mem_to_reg,
                       reg_write:  id_reg_write,
                       branch:     id_branch};

    // Bubbles zero every field so a squashed slot can never match in forwarding.
    always_comb begin
        valid_d   = 1'b0;
        ctrl_d    = CTRL_BUBBLE;
        pc_d      = '0;
        rs1_dat_d = '0;
        rs2_dat_d = '0;
        imm_d     = '0;
        rs1_d     = '0;
        rs2_d     = '0;
        rd_d      = '0;
        alu_d     = '0;
        if (!ex_flush && !load_use) begin
            valid_d   = id_valid;
            ctrl_d    = id_ctrl;
            pc_d      = id_pc;
            rs1_dat_d = id_rs1_data;
            rs2_dat_d = id_rs2_data;
            imm_d     = id_imm;
            rs1_d     = id_rs1;
            rs2_d     = id_rs2;
            rd_d      = id_rd;
            alu_d     = id_alu_ctrl;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_if_id && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ex_flush && (flush_cnt_q != '1))    flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            ctrl_q      <= CTRL_BUBBLE;
            pc_q        <= '0;
            rs1_dat_q   <= '0;
            rs2_dat_q   <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            alu_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            pc_q        <= pc_d;
            rs1_dat_q   <= rs1_dat_d;
            rs2_dat_q   <= rs2_dat_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            alu_q       <= alu_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign ex_rs1_data   = rs1_dat_q;
    assign ex_rs2_data   = rs2_dat_q;
    assign ex_imm        = imm_q;
    assign ex_rs1        = rs1_q;
    assign ex_rs2        = rs2_q;
    assign ex_rd         = rd_q;
    assign ex_alu_ctrl   = alu_q;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_branch     = ctrl_q.branch;
    assign stall_count   = stall_cnt_q;
    assign flush_count   = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a default-width instance and a 4-bit-counter
// instance share one stimulus stream.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic [3:0]  id_alu_ctrl;
    logic        id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_branch;
    logic        ex_flush;

    logic        stall_if_id, flush_if_id, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_ctrl;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch;
    logic [31:0] stall_count, flush_count;

    logic        s4_stall, s4_flush, s4_valid;
    logic [31:0] s4_pc, s4_rs1_data, s4_rs2_data, s4_imm;
    logic [4:0]  s4_rs1, s4_rs2, s4_rd;
    logic [3:0]  s4_alu_ctrl;
    logic        s4_alu_src, s4_mem_read, s4_mem_write, s4_mem_to_reg, s4_reg_write, s4_branch;
    logic [3:0]  s4_stall_count, s4_flush_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
        .id_branch(id_branch), .ex_flush(ex_flush),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    id_ex_stage #(.CNT_W(4)) dut_c4 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
        .id_branch(id_branch), .ex_flush(ex_flush),
        .stall_if_id(s4_stall), .flush_if_id(s4_flush), .ex_valid(s4_valid),
        .ex_pc(s4_pc), .ex_rs1_data(s4_rs1_data), .ex_rs2_data(s4_rs2_data), .ex_imm(s4_imm),
        .ex_rs1(s4_rs1), .ex_rs2(s4_rs2), .ex_rd(s4_rd), .ex_alu_ctrl(s4_alu_ctrl),
        .ex_alu_src(s4_alu_src), .ex_mem_read(s4_mem_read), .ex_mem_write(s4_mem_write),
        .ex_mem_to_reg(s4_mem_to_reg), .ex_reg_write(s4_reg_write), .ex_branch(s4_branch),
        .stall_count(s4_stall_count), .flush_count(s4_flush_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_pc = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_alu_ctrl = '0; id_alu_src = 0; id_mem_read = 0; id_mem_write = 0;
        id_mem_to_reg = 0; id_reg_write = 0; id_branch = 0; ex_flush = 0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        clear_id();
        id_valid = 1; id_pc = 32'h200; id_rs1 = 5'd2; id_uses_rs1 = 1; id_rd = rd;
        id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1; id_alu_src = 1; id_imm = 32'd8;
    endtask

    task automatic set_consumer(input logic [4:0] rs1, input logic [4:0] rs2);
        clear_id();
        id_valid = 1; id_pc = 32'h204; id_rs1 = rs1; id_rs2 = rs2;
        id_uses_rs1 = 1; id_uses_rs2 = 1; id_rd = 5'd9; id_reg_write = 1;
    endtask

    initial begin
        // Reset with random inputs
        reset = 1;
        id_valid = $urandom; id_pc = $urandom; id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
        id_rd = 5'($urandom); id_uses_rs1 = $urandom; id_uses_rs2 = $urandom;
        id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        id_alu_ctrl = 4'($urandom); id_alu_src = $urandom; id_mem_read = $urandom;
        id_mem_write = $urandom; id_mem_to_reg = $urandom; id_reg_write = $urandom;
        id_branch = $urandom; ex_flush = 0;
        tick(); tick();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_rd", ex_rd, 0);
        check("rst_ex_pc", ex_pc, 0);
        check("rst_ex_reg_write", ex_reg_write, 0);
        check("rst_ex_mem_read", ex_mem_read, 0);
        check("rst_stall_count", stall_count, 0);
        check("rst_flush_count", flush_count, 0);
        check("rst_stall_if_id", stall_if_id, 0);
        check("rst_flush_if_id", flush_if_id, 0);
        clear_id();
        reset = 0;

        // Plain capture
        id_valid = 1; id_rd = 5'd5; id_reg_write = 1; id_pc = 32'h100;
        id_rs1_data = 32'hAAAA0001; id_imm = 32'hFFFFFFF0; id_alu_ctrl = 4'd1; id_alu_src = 1;
        tick();
        check("cap_ex_valid", ex_valid, 1);
        check("cap_ex_rd", ex_rd, 5);
        check("cap_ex_reg_write", ex_reg_write, 1);
        check("cap_ex_pc", ex_pc, 32'h100);
        check("cap_ex_rs1_data", ex_rs1_data, 32'hAAAA0001);
        check("cap_ex_imm", ex_imm, 32'hFFFFFFF0);
        check("cap_ex_alu_ctrl", ex_alu_ctrl, 1);

        // Load-use on rs2: one-cycle stall, bubble, then capture
        set_load(5'd7);
        tick();
        check("ld_ex_mem_read", ex_mem_read, 1);
        set_consumer(5'd3, 5'd7);
        #1;
        check("lu_stall", stall_if_id, 1);
        check("lu_flush", flush_if_id, 0);
        tick(); exp_stall++;
        check("lu_bub_valid", ex_valid, 0);
        check("lu_bub_reg_write", ex_reg_write, 0);
        check("lu_bub_rd", ex_rd, 0);
        check("lu_bub_pc", ex_pc, 0);
        check("lu_stall_count", stall_count, exp_stall);
        check("lu_stall_released", stall_if_id, 0);
        tick();
        check("lu_cap_valid", ex_valid, 1);
        check("lu_cap_rd", ex_rd, 9);
        check("lu_cap_rs1", ex_rs1, 3);
        check("lu_cap_rs2", ex_rs2, 7);

        // Load to x0 never stalls
        set_load(5'd0);
        tick();
        set_consumer(5'd0, 5'd4);
        #1;
        check("x0_stall", stall_if_id, 0);
        tick();
        check("x0_ex_valid", ex_valid, 1);
        check("x0_stall_count", stall_count, exp_stall);

        // Flush and load-use together: flush wins
        set_load(5'd7);
        tick();
        set_consumer(5'd1, 5'd7);
        ex_flush = 1;
        #1;
        check("fl_stall", stall_if_id, 0);
        check("fl_flush", flush_if_id, 1);
        tick();
        check("fl_bub_valid", ex_valid, 0);
        check("fl_bub_rd", ex_rd, 0);
        check("fl_flush_count", flush_count, 1);
        check("fl_stall_count", stall_count, exp_stall);
        check("fl_c4_flush_count", s4_flush_count, 1);
        ex_flush = 0;

        // Register not actually read (LUI-like)
        set_load(5'd7);
        tick();
        set_consumer(5'd7, 5'd0);
        id_uses_rs1 = 0; id_uses_rs2 = 0; id_alu_ctrl = 4'd10;
        #1;
        check("lui_stall", stall_if_id, 0);
        tick();
        check("lui_ex_valid", ex_valid, 1);
        check("lui_ex_alu_ctrl", ex_alu_ctrl, 10);

        // Invalid ID slot never stalls
        set_load(5'd7);
        tick();
        set_consumer(5'd7, 5'd7);
        id_valid = 0;
        #1;
        check("inv_stall", stall_if_id, 0);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            set_load(5'd7);
            tick();
            set_consumer(5'd7, 5'd2);
            #1;
            if (stall_if_id !== 1'b1) check("sat_stall_event", stall_if_id, 1);
            tick(); exp_stall++;
        end
        check("sat_wide_count", stall_count, exp_stall);
        check("sat_c4_count", s4_stall_count, 15);
        set_load(5'd7);
        tick();
        set_consumer(5'd7, 5'd2);
        tick(); exp_stall++;
        check("sat_wide_next", stall_count, exp_stall);
        check("sat_c4_hold", s4_stall_count, 15);

        // Reset mid-stall
        set_load(5'd7);
        tick();
        set_consumer(5'd7, 5'd2);
        #1;
        check("rms_stall_before", stall_if_id, 1);
        reset = 1;
        #1;
        check("rms_ex_valid", ex_valid, 0);
        check("rms_ex_mem_read", ex_mem_read, 0);
        check("rms_ex_rd", ex_rd, 0);
        check("rms_stall_count", stall_count, 0);
        check("rms_c4_stall_count", s4_stall_count, 0);
        check("rms_stall_if_id", stall_if_id, 0);
        tick();
        reset = 0;
        #1;
        check("rms_post_stall", stall_if_id, 0);
        tick();
        check("rms_post_valid", ex_valid, 1);
        check("rms_post_rd", ex_rd, 9);
        check("rms_post_count", stall_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
